// File: rtl/imu_boxcar_filter_if.sv
// Sample/result bundle between the IMU poller and the boxcar filter.
// The filter connects through the slave modport; the poller side uses master.
interface imu_boxcar_filter_if #(
  parameter int WIDTH = 10
);
  logic                    Flush;
  logic                    SampleValid;
  logic signed [WIDTH-1:0] AccelX;
  logic signed [WIDTH-1:0] AccelY;
  logic signed [WIDTH-1:0] AccelZ;
  logic signed [WIDTH-1:0] AccelXOut;
  logic signed [WIDTH-1:0] AccelYOut;
  logic signed [WIDTH-1:0] AccelZOut;
  logic                    DataReady;
  logic                    Primed;
  logic                    Overrun;

  modport master (
    output Flush, SampleValid, AccelX, AccelY, AccelZ,
    input  AccelXOut, AccelYOut, AccelZOut, DataReady, Primed, Overrun
  );

  modport slave (
    input  Flush, SampleValid, AccelX, AccelY, AccelZ,
    output AccelXOut, AccelYOut, AccelZOut, DataReady, Primed, Overrun
  );
endinterface

// File: rtl/imu_boxcar_filter.sv
// Three-axis moving-average filter over the last 2^LOG2_DEPTH signed samples.
// One sample is accepted per IDLE->SUM->WRITE pass; extra strobes set Overrun.
module imu_boxcar_filter #(
  parameter int WIDTH      = 10,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                Clock,
  input  logic                Reset_n,
  imu_boxcar_filter_if.slave  bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SUM   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

  logic [1:0]            r_state;
  logic [LOG2_DEPTH-1:0] r_ptr;
  logic [LOG2_DEPTH:0]   r_count;
  logic                  r_ready;
  logic                  r_overrun;

  logic signed [WIDTH-1:0] w_in  [3];
  logic signed [WIDTH-1:0] w_out [3];

  assign w_in[0] = bus.AccelX;
  assign w_in[1] = bus.AccelY;
  assign w_in[2] = bus.AccelZ;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (bus.Flush) begin
        r_state   <= S_IDLE;
        r_ptr     <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (bus.SampleValid && r_state != S_IDLE)
          r_overrun <= 1'b1;
        case (r_state)
          S_IDLE: if (bus.SampleValid) r_state <= S_SUM;
          S_SUM: begin
            r_ptr   <= r_ptr + 1'b1;
            if (r_count != FULL)
              r_count <= r_count + 1'b1;
            r_state <= S_WRITE;
          end
          S_WRITE: begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Per-axis datapath: latch, running-sum update with eviction, shift-out.
  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic signed [WIDTH-1:0] r_new;
    logic signed [WIDTH-1:0] r_out;
    logic signed [SW-1:0]    r_sum;
    logic signed [WIDTH-1:0] r_hist [DEPTH];

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        r_new  <= '0;
        r_out  <= '0;
        r_sum  <= '0;
        r_hist <= '{default: '0};
      end else if (bus.Flush) begin
        r_sum  <= '0;
        r_hist <= '{default: '0};
      end else begin
        case (r_state)
          S_IDLE: if (bus.SampleValid) r_new <= w_in[a];
          S_SUM: begin
            r_sum         <= r_sum + SW'(r_new) - SW'(r_hist[r_ptr]);
            r_hist[r_ptr] <= r_new;
          end
          S_WRITE: r_out <= WIDTH'(r_sum >>> LOG2_DEPTH);
          default: ;
        endcase
      end
    end

    assign w_out[a] = r_out;
  end

  assign bus.AccelXOut = w_out[0];
  assign bus.AccelYOut = w_out[1];
  assign bus.AccelZOut = w_out[2];
  assign bus.DataReady = r_ready;
  assign bus.Primed    = (r_count == FULL);
  assign bus.Overrun   = r_overrun;
endmodule

// File: tb/tb_imu_boxcar_filter.sv
// Directed plus random stimulus for imu_boxcar_filter, checked against a
// queue-based moving-average model with floor division.
module tb_imu_boxcar_filter;
  localparam int WIDTH = 10;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imu_boxcar_filter_if #(.WIDTH(WIDTH)) ifc ();

  imu_boxcar_filter #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (ifc)
  );

  // Reference model: last DEPTH accepted samples per axis; missing entries count as zero.
  int hq[3][$];
  int acc_n = 0;
  bit m_ov = 1'b0;
  int m_out[3] = '{0, 0, 0};

  function automatic int m_mean(int a);
    int s = 0;
    foreach (hq[a][i]) s += hq[a][i];
    if (s >= 0) return s / DEPTH;
    return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  function automatic void m_accept(int x, int y, int z);
    hq[0].push_back(x); hq[1].push_back(y); hq[2].push_back(z);
    for (int a = 0; a < 3; a++)
      if (hq[a].size() > DEPTH) void'(hq[a].pop_front());
    acc_n++;
  endfunction

  function automatic void m_clear();
    for (int a = 0; a < 3; a++) hq[a].delete();
    acc_n = 0;
    m_ov = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_x"}, ifc.AccelXOut, m_out[0]);
    chk({tag, "_y"}, ifc.AccelYOut, m_out[1]);
    chk({tag, "_z"}, ifc.AccelZOut, m_out[2]);
  endtask

  task automatic send(input int x, input int y, input int z);
    @(negedge clk);
    chk("dr_idle", ifc.DataReady, 0);
    ifc.SampleValid = 1'b1;
    ifc.AccelX = WIDTH'(x); ifc.AccelY = WIDTH'(y); ifc.AccelZ = WIDTH'(z);
    m_accept(x, y, z);
    @(negedge clk);
    ifc.SampleValid = 1'b0;
    chk("dr_e0", ifc.DataReady, 0);
    @(negedge clk);
    chk("dr_e1", ifc.DataReady, 0);
    chk("primed", ifc.Primed, (acc_n >= DEPTH) ? 1 : 0);
    @(negedge clk);
    for (int a = 0; a < 3; a++) m_out[a] = m_mean(a);
    chk("dr_e2", ifc.DataReady, 1);
    chk_outs("mean");
    chk("overrun", ifc.Overrun, m_ov ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_clear();
    m_out = '{0, 0, 0};
    @(negedge clk);
    chk_outs("rst");
    chk("rst_primed", ifc.Primed, 0);
    chk("rst_overrun", ifc.Overrun, 0);
    chk("rst_dr", ifc.DataReady, 0);
    rst_n = 1'b1;
  endtask

  task automatic overrun_pair(input int x1, input int x2);
    @(negedge clk);
    ifc.SampleValid = 1'b1;
    ifc.AccelX = WIDTH'(x1); ifc.AccelY = '0; ifc.AccelZ = '0;
    m_accept(x1, 0, 0);
    @(negedge clk);
    ifc.AccelX = WIDTH'(x2);
    m_ov = 1'b1;
    chk("ovr_dr_e0", ifc.DataReady, 0);
    @(negedge clk);
    ifc.SampleValid = 1'b0;
    chk("ovr_dr_e1", ifc.DataReady, 0);
    chk("ovr_flag", ifc.Overrun, 1);
    @(negedge clk);
    for (int a = 0; a < 3; a++) m_out[a] = m_mean(a);
    chk("ovr_dr_e2", ifc.DataReady, 1);
    chk_outs("ovr_mean");
    repeat (3) begin
      @(negedge clk);
      chk("ovr_dr_after", ifc.DataReady, 0);
    end
    chk("ovr_sticky", ifc.Overrun, 1);
  endtask

  initial begin
    ifc.Flush = 1'b0;
    ifc.SampleValid = 1'b0;
    ifc.AccelX = '0; ifc.AccelY = '0; ifc.AccelZ = '0;

    do_reset();

    // Ramp: output climbs 10 per sample while zero history is displaced
    for (int k = 1; k <= DEPTH; k++) send(80, -80, 0);
    chk("ramp_x8", ifc.AccelXOut, 80);
    chk("ramp_y8", ifc.AccelYOut, -80);

    // Ninth sample evicts the oldest entry
    send(0, -80, 0);
    chk("wrap_x", ifc.AccelXOut, 70);

    // Flush colliding with a strobe while primed
    @(negedge clk);
    ifc.Flush = 1'b1; ifc.SampleValid = 1'b1; ifc.AccelX = 10'sd123;
    @(negedge clk);
    ifc.Flush = 1'b0; ifc.SampleValid = 1'b0;
    m_clear();
    chk("col_primed", ifc.Primed, 0);
    chk("col_overrun", ifc.Overrun, 0);
    repeat (3) begin
      chk("col_dr", ifc.DataReady, 0);
      chk_outs("col_hold");
      @(negedge clk);
    end
    send(40, 0, 0);
    chk("col_next_x", ifc.AccelXOut, 5);

    // Overrun, then flush clears it
    overrun_pair(200, -300);
    @(negedge clk);
    ifc.Flush = 1'b1;
    @(negedge clk);
    ifc.Flush = 1'b0;
    m_clear();
    chk("flush_overrun", ifc.Overrun, 0);
    chk_outs("flush_hold");

    // Rounding toward minus infinity and extremes
    do_reset();
    send(-3, 3, -8);
    chk("neg_round_x", ifc.AccelXOut, -1);
    do_reset();
    for (int k = 0; k < DEPTH; k++) send(-512, 511, 0);
    chk("min_x", ifc.AccelXOut, -512);
    chk("max_y", ifc.AccelYOut, 511);
    for (int k = 0; k < DEPTH; k++) send(511, -512, 1);
    chk("max_x", ifc.AccelXOut, 511);

    // Random samples over the full signed range
    for (int k = 0; k < 24; k++)
      send(int'($urandom_range(0, 1023)) - 512,
           int'($urandom_range(0, 1023)) - 512,
           int'($urandom_range(0, 1023)) - 512);

    // Reset dropped while a sample is in SUM
    overrun_pair(17, 5);
    @(negedge clk);
    ifc.SampleValid = 1'b1; ifc.AccelX = 10'sd99;
    @(negedge clk);
    ifc.SampleValid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    m_clear();
    m_out = '{0, 0, 0};
    chk_outs("midrst");
    chk("midrst_primed", ifc.Primed, 0);
    chk("midrst_overrun", ifc.Overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_dr", ifc.DataReady, 0);
    end
    chk_outs("midrst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imu_boxcar_filter.md
Name: imu_boxcar_filter

Overview:
- Three-axis moving-average (boxcar) filter for raw 10-bit signed accelerometer samples.
- Sits between the I2C IMU poller and the sensor-fusion angle calculators.
- Consumes one X/Y/Z sample triple per SampleValid pulse.
- Emits the mean of the last 2^LOG2_DEPTH triples with a one-cycle DataReady pulse.

Parameters:
- WIDTH, 10, sample width in bits; two's-complement signed.
- LOG2_DEPTH, 3, log2 of the window length (DEPTH = 2^LOG2_DEPTH = 8). Legal range 1..6.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous clear of the filter history.
- SampleValid  input  1  one-cycle strobe; AccelX/Y/Z are valid in the same cycle.
- AccelX  input  WIDTH  raw X sample, signed.
- AccelY  input  WIDTH  raw Y sample, signed.
- AccelZ  input  WIDTH  raw Z sample, signed.
- AccelXOut  output  WIDTH  filtered X mean, signed.
- AccelYOut  output  WIDTH  filtered Y mean, signed.
- AccelZOut  output  WIDTH  filtered Z mean, signed.
- DataReady  output  1  one-cycle pulse when the outputs update.
- Primed  output  1  high once DEPTH samples have been accepted since the last reset or flush.
- Overrun  output  1  sticky; a sample arrived while the filter was busy.

Behaviour:
- Reset (Reset_n low, asynchronous) clears:
  - all outputs, the history buffer, per-axis running sums, write pointer and fill count;
  - the FSM returns to IDLE.
- History buffer: DEPTH x 3 axes of WIDTH-bit registers.
- Running sums: one per axis, signed, WIDTH+LOG2_DEPTH bits wide. They cannot overflow, so no saturation is needed.
- FSM states: IDLE, SUM, WRITE.
  - IDLE: when SampleValid is high at edge E0, latch AccelX/Y/Z and go to SUM. Otherwise stay in IDLE.
  - SUM (edge E1):
    - sum <= sum + new - buffer[ptr], per axis;
    - buffer[ptr] <= new;
    - ptr <= ptr + 1, wrapping modulo DEPTH;
    - fill count increments, saturating at DEPTH;
    - go to WRITE.
  - WRITE (edge E2):
    - AccelXOut/YOut/ZOut <= sum >>> LOG2_DEPTH (arithmetic shift, rounds toward minus infinity);
    - DataReady is high for exactly the cycle following E2;
    - go to IDLE.
- Latency: DataReady is asserted 2 edges after the accepting edge. Maximum accepted rate is one sample per 3 cycles.
- Before Primed, the buffer's zero entries take part in the mean, so the output ramps up toward the input. This is intentional.
- Primed goes high at E1 of the DEPTH-th accepted sample and stays high until the next reset or flush.
- SampleValid high in SUM or WRITE:
  - the sample is dropped;
  - Overrun is set and remains set until reset or flush;
  - the in-flight sample still completes normally.
- Flush high at any edge:
  - clears the buffer, sums, pointer, count, Primed and Overrun;
  - FSM goes to IDLE; an in-flight sample is abandoned and produces no DataReady;
  - outputs hold their last value.
- Flush and SampleValid in the same cycle: Flush wins, the sample is dropped, and Overrun is not set.
- Reset asserted mid-operation: immediate clear, and no DataReady is produced.
- Outputs are stable between DataReady pulses.

Test Plan:
- Ramp: after reset, 8 samples of X=+80, Y=-80, Z=0, spaced 4 cycles apart.
  - After sample k (k=1..8), AccelXOut = 10k and AccelYOut = -10k.
  - Primed rises with the 8th sample; DataReady pulses exactly 8 times, 2 edges after each strobe.
- Wrap-around: continuing the ramp, feed a 9th sample with X=0.
  - Sum becomes 560, so AccelXOut = 70; the oldest 80 is evicted and ptr wraps to 1.
- Negative rounding: after reset, one sample with X=-3.
  - AccelXOut = -1 (floor of -3/8).
  - Extreme values X=-512 x8 give -512; X=+511 x8 give +511.
- Overrun: SampleValid at edge E0 and again at E1.
  - Only the first sample is filtered, Overrun = 1, and exactly one DataReady pulse occurs.
  - A subsequent Flush returns Overrun to 0.
- Flush collision: assert Flush and SampleValid together while Primed = 1.
  - Primed drops to 0, no DataReady, outputs hold.
  - The next sample X=+40 gives AccelXOut = 5.
- Reset mid-operation: drop Reset_n during SUM.
  - Outputs, Primed and Overrun read 0 immediately, and no DataReady occurs after release.
